stat_cnt_bank: RTL

//   Multi-channel statistics counter bank: the parametrised successor of the single 48-bit

---
 rtl/stat_cnt_bank.sv | 65 ++++++
 1 files changed

// File: rtl/stat_cnt_bank.sv
// stat_cnt_bank: multi-channel statistics counters with snapshot shadows and a registered read port
module stat_cnt_bank #(
  parameter int NUM_CH   = 8,
  parameter int CNT_W    = 48,
  parameter int INC_W    = 16,
  parameter int SATURATE = 0,
  parameter int AW       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       inc_en,
  input  logic [NUM_CH*INC_W-1:0] inc_val,
  input  logic [NUM_CH-1:0]       clr,
  input  logic                    clr_all,
  input  logic                    snap,
  input  logic                    rd_en,
  input  logic [AW-1:0]           rd_addr,
  output logic [CNT_W-1:0]        rd_data,
  output logic                    rd_ovf,
  output logic                    rd_vld,
  output logic [NUM_CH-1:0]       ovf
);
  logic [CNT_W-1:0] cnt [NUM_CH];
  logic [CNT_W-1:0] shd [NUM_CH];
  logic [CNT_W:0]   sum [NUM_CH];
  logic [NUM_CH-1:0] shd_ovf;
  logic in_rng;
  assign in_rng = int'(rd_addr) < NUM_CH;
  // carry-extended sum per channel; the top bit is the overflow indication
  always_comb
    for (int i = 0; i < NUM_CH; i++)
      sum[i] = {1'b0, cnt[i]} + {{(CNT_W+1-INC_W){1'b0}}, inc_val[i*INC_W +: INC_W]};
  // counter update: clear beats increment, overflow either wraps or pins at all-ones
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      if (rst || clr_all || clr[i]) begin
        cnt[i] <= '0;
        ovf[i] <= 1'b0;
      end else if (inc_en[i]) begin
        cnt[i] <= (sum[i][CNT_W] && SATURATE != 0) ? '1 : sum[i][CNT_W-1:0];
        ovf[i] <= ovf[i] | sum[i][CNT_W];
      end
  // shadows capture pre-update counters so snap+clear is an atomic read-and-clear
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) shd[i] <= '0;
      shd_ovf <= '0;
    end else if (snap) begin
      shd     <= cnt;
      shd_ovf <= ovf;
    end
  // one-cycle read of the shadows; out-of-range addresses return zero
  always_ff @(posedge clk)
    if (rst) begin
      rd_vld  <= 1'b0;
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else begin
      rd_vld <= rd_en;
      if (rd_en) begin
        rd_data <= in_rng ? shd[rd_addr] : '0;
        rd_ovf  <= in_rng & shd_ovf[rd_addr];
      end
    end
endmodule
